// File: rtl/ring_monitor_if.sv
// Bus bundle between a ring-counter driver (master) and ring_monitor (slave).
interface ring_monitor_if #(
  parameter int WIDTH = 8,
  parameter int LAP_W = 8
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             en;
  logic [WIDTH-1:0] ring_in;
  logic             dir;
  logic             clr_err;
  logic [PW-1:0]    pos;
  logic             pos_valid;
  logic             locked;
  logic [LAP_W-1:0] lap_count;
  logic             lap_pulse;
  logic             err_illegal;
  logic             err_skip;
  logic             err_stall;

  modport master (
    output en, ring_in, dir, clr_err,
    input  pos, pos_valid, locked, lap_count, lap_pulse,
    input  err_illegal, err_skip, err_stall
  );

  modport slave (
    input  en, ring_in, dir, clr_err,
    output pos, pos_valid, locked, lap_count, lap_pulse,
    output err_illegal, err_skip, err_stall
  );
endinterface

// File: rtl/ring_monitor.sv
// Checks a one-hot ring counter: locks onto the hot bit, follows the rotation,
// counts laps, and keeps sticky flags for illegal, skipped and stalled samples.
module ring_monitor #(
  parameter int WIDTH       = 8,
  parameter int STALL_LIMIT = 16,
  parameter int LAP_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  ring_monitor_if.slave bus
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [PW-1:0] POS_MAX   = PW'(WIDTH - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
  localparam logic [SW-1:0] STALL_PRE = SW'(STALL_LIMIT - 1);

  typedef enum logic {ACQUIRE, TRACK} state_t;

  state_t           state_reg;
  logic [PW-1:0]    pos_reg;
  logic             pos_valid_reg;
  logic [LAP_W-1:0] lap_count_reg;
  logic             lap_pulse_reg;
  logic             err_illegal_reg;
  logic             err_skip_reg;
  logic             err_stall_reg;
  logic [SW-1:0]    stall_cnt_reg;

  logic             one_hot;
  logic [PW-1:0]    hot_idx;
  logic [PW-1:0]    pos_next;
  logic             lap_wrap;

  // Decode the sample: one-hot test and index of the hot bit.
  always_comb begin
    one_hot = $onehot(bus.ring_in);
    hot_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.ring_in[i]) hot_idx = PW'(i);
    end
  end

  // Expected next position for the requested direction, and whether that step closes a lap.
  always_comb begin
    if (bus.dir) begin
      pos_next = (pos_reg == '0) ? POS_MAX : pos_reg - 1'b1;
      lap_wrap = (pos_reg == '0);
    end else begin
      pos_next = (pos_reg == POS_MAX) ? '0 : pos_reg + 1'b1;
      lap_wrap = (pos_reg == POS_MAX);
    end
  end

  // Tracking FSM with registered outputs; an error event wins over a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ACQUIRE;
      pos_reg         <= '0;
      pos_valid_reg   <= 1'b0;
      lap_count_reg   <= '0;
      lap_pulse_reg   <= 1'b0;
      err_illegal_reg <= 1'b0;
      err_skip_reg    <= 1'b0;
      err_stall_reg   <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      lap_pulse_reg <= 1'b0;
      if (bus.clr_err) begin
        err_illegal_reg <= 1'b0;
        err_skip_reg    <= 1'b0;
        err_stall_reg   <= 1'b0;
      end
      if (bus.en) begin
        unique case (state_reg)
          ACQUIRE: begin
            if (one_hot) begin
              pos_reg       <= hot_idx;
              pos_valid_reg <= 1'b1;
              stall_cnt_reg <= '0;
              state_reg     <= TRACK;
            end else begin
              err_illegal_reg <= 1'b1;
              pos_valid_reg   <= 1'b0;
            end
          end
          TRACK: begin
            if (!one_hot) begin
              err_illegal_reg <= 1'b1;
              pos_valid_reg   <= 1'b0;
              state_reg       <= ACQUIRE;
            end else if (hot_idx == pos_reg) begin
              // Repeat of the current position: count toward a stall, flag once on arrival.
              if (stall_cnt_reg != STALL_MAX) stall_cnt_reg <= stall_cnt_reg + 1'b1;
              if (stall_cnt_reg == STALL_PRE) err_stall_reg <= 1'b1;
            end else if (hot_idx == pos_next) begin
              pos_reg       <= pos_next;
              stall_cnt_reg <= '0;
              if (lap_wrap) begin
                lap_count_reg <= lap_count_reg + 1'b1;
                lap_pulse_reg <= 1'b1;
              end
            end else begin
              // Out-of-order step: drop lock; this sample is not trusted for re-lock.
              err_skip_reg  <= 1'b1;
              pos_valid_reg <= 1'b0;
              state_reg     <= ACQUIRE;
            end
          end
          default: state_reg <= ACQUIRE;
        endcase
      end
    end
  end

  assign bus.pos         = pos_reg;
  assign bus.pos_valid   = pos_valid_reg;
  assign bus.locked      = (state_reg == TRACK);
  assign bus.lap_count   = lap_count_reg;
  assign bus.lap_pulse   = lap_pulse_reg;
  assign bus.err_illegal = err_illegal_reg;
  assign bus.err_skip    = err_skip_reg;
  assign bus.err_stall   = err_stall_reg;
endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor with an arithmetic reference model compared every cycle.
module tb_ring_monitor;
  localparam int W = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ring_monitor_if #(.WIDTH(W), .LAP_W(8)) bus ();

  ring_monitor #(.WIDTH(W), .STALL_LIMIT(L), .LAP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Reference state in plain integers.
  int m_locked, m_pos, m_valid, m_laps, m_pulse, m_stall;
  int m_ill, m_skip, m_stl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rules applied to the sampled inputs with plain arithmetic.
  always @(posedge clk) begin
    int ones, idx, nxt, wrap, nstall;
    if (rst) begin
      m_locked <= 0; m_pos <= 0; m_valid <= 0; m_laps <= 0; m_pulse <= 0;
      m_stall <= 0; m_ill <= 0; m_skip <= 0; m_stl <= 0;
    end else begin
      int ill, skp, stl;
      ill = bus.clr_err ? 0 : m_ill;
      skp = bus.clr_err ? 0 : m_skip;
      stl = bus.clr_err ? 0 : m_stl;
      m_pulse <= 0;
      if (bus.en) begin
        ones = $countones(bus.ring_in);
        idx  = $clog2(bus.ring_in);
        nxt  = (m_pos + (bus.dir ? W - 1 : 1)) % W;
        if (m_locked == 0) begin
          if (ones == 1) begin
            m_pos <= idx; m_valid <= 1; m_stall <= 0; m_locked <= 1;
          end else begin
            ill = 1; m_valid <= 0;
          end
        end else if (ones != 1) begin
          ill = 1; m_valid <= 0; m_locked <= 0;
        end else if (idx == m_pos) begin
          nstall = (m_stall + 1 > L) ? L : m_stall + 1;
          if (nstall == L && m_stall != L) stl = 1;
          m_stall <= nstall;
        end else if (idx == nxt) begin
          wrap = bus.dir ? (nxt == W - 1) : (nxt == 0);
          m_pos <= nxt; m_stall <= 0;
          if (wrap != 0) begin
            m_laps <= (m_laps + 1) % 256; m_pulse <= 1;
          end
        end else begin
          skp = 1; m_valid <= 0; m_locked <= 0;
        end
      end
      m_ill <= ill; m_skip <= skp; m_stl <= stl;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_pos",       int'(bus.pos),         m_pos);
      chk("cyc_pos_valid", int'(bus.pos_valid),   m_valid);
      chk("cyc_locked",    int'(bus.locked),      m_locked);
      chk("cyc_lap_count", int'(bus.lap_count),   m_laps);
      chk("cyc_lap_pulse", int'(bus.lap_pulse),   m_pulse);
      chk("cyc_err_ill",   int'(bus.err_illegal), m_ill);
      chk("cyc_err_skip",  int'(bus.err_skip),    m_skip);
      chk("cyc_err_stall", int'(bus.err_stall),   m_stl);
    end
  end

  // One clock with the given inputs; returns just after the falling edge.
  task automatic step(input bit e, input logic [7:0] r, input bit d, input bit c, input bit rs = 0);
    rst = rs; bus.en = e; bus.ring_in = r; bus.dir = d; bus.clr_err = c;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("step rst=%0b en=%0b ring=%02h dir=%0b clr=%0b -> pos=%0d valid=%0b lock=%0b laps=%0d pulse=%0b ill=%0b skip=%0b stall=%0b",
             rs, e, r, d, c, bus.pos, bus.pos_valid, bus.locked, bus.lap_count, bus.lap_pulse,
             bus.err_illegal, bus.err_skip, bus.err_stall);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    step(0, 8'h00, 0, 0, 1);
  endtask

  initial begin
    logic [7:0] r;
    bus.en = 0; bus.ring_in = 0; bus.dir = 0; bus.clr_err = 0;
    do_reset();
    checking = 1;
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_pos_valid", int'(bus.pos_valid), 0);
    chk("rst_lap_count", int'(bus.lap_count), 0);

    // Normal rotation up with one lap.
    step(1, 8'h01, 0, 0);
    chk("up_lock", int'(bus.locked), 1);
    chk("up_pos0", int'(bus.pos), 0);
    for (int i = 1; i < 8; i++) begin
      r = 8'h01 << i;
      step(1, r, 0, 0);
      chk("up_pos", int'(bus.pos), i);
      chk("up_nopulse", int'(bus.lap_pulse), 0);
    end
    step(1, 8'h01, 0, 0);
    chk("up_lap", int'(bus.lap_count), 1);
    chk("up_pulse", int'(bus.lap_pulse), 1);
    chk("up_pos_wrap", int'(bus.pos), 0);
    step(0, 8'h01, 0, 0);
    chk("up_pulse_once", int'(bus.lap_pulse), 0);
    chk("up_no_err", int'(bus.err_illegal | bus.err_skip | bus.err_stall), 0);

    // Illegal sample, relock, clear.
    do_reset();
    step(1, 8'h04, 0, 0);
    step(1, 8'h0C, 0, 0);
    chk("ill_flag", int'(bus.err_illegal), 1);
    chk("ill_unlock", int'(bus.locked), 0);
    chk("ill_valid", int'(bus.pos_valid), 0);
    step(1, 8'h08, 0, 0);
    chk("ill_relock", int'(bus.locked), 1);
    chk("ill_relock_pos", int'(bus.pos), 3);
    step(0, 8'h08, 0, 1);
    chk("ill_clr", int'(bus.err_illegal), 0);
    chk("ill_clr_keeps_lock", int'(bus.locked), 1);

    // Skip detection; the skipped sample does not relock.
    do_reset();
    step(1, 8'h04, 0, 0);
    step(1, 8'h10, 0, 0);
    chk("skip_flag", int'(bus.err_skip), 1);
    chk("skip_unlock", int'(bus.locked), 0);
    step(1, 8'h20, 0, 0);
    chk("skip_relock", int'(bus.locked), 1);
    chk("skip_pos", int'(bus.pos), 5);
    chk("skip_laps", int'(bus.lap_count), 0);

    // Stall counting across disabled cycles.
    do_reset();
    step(1, 8'h04, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h04, 0, 0);
    chk("stall_early", int'(bus.err_stall), 0);
    step(0, 8'h04, 0, 0);
    step(0, 8'h04, 0, 0);
    chk("stall_en0", int'(bus.err_stall), 0);
    step(1, 8'h04, 0, 0);
    chk("stall_trip", int'(bus.err_stall), 1);
    step(1, 8'h08, 0, 0);
    chk("stall_sticky", int'(bus.err_stall), 1);
    chk("stall_pos", int'(bus.pos), 3);

    // Down direction lap, then clear colliding with an error.
    do_reset();
    step(1, 8'h02, 1, 0);
    step(1, 8'h01, 1, 0);
    step(1, 8'h80, 1, 0);
    chk("down_lap", int'(bus.lap_count), 1);
    chk("down_pulse", int'(bus.lap_pulse), 1);
    chk("down_pos", int'(bus.pos), 7);
    step(1, 8'h00, 1, 1);
    chk("collide_ill", int'(bus.err_illegal), 1);

    // Reset in the middle of operation.
    do_reset();
    step(1, 8'h01, 0, 0);
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 1; i <= 8; i++) begin
        r = 8'h01 << (i % 8);
        step(1, r, 0, 0);
      end
    end
    chk("mid_laps", int'(bus.lap_count), 3);
    step(1, 8'h04, 0, 0);
    step(1, 8'h08, 0, 0);
    chk("mid_skip", int'(bus.err_skip), 1);
    chk("mid_locked", int'(bus.locked), 1);
    step(0, 8'h08, 0, 0, 1);
    chk("mid_rst_laps", int'(bus.lap_count), 0);
    chk("mid_rst_skip", int'(bus.err_skip), 0);
    chk("mid_rst_lock", int'(bus.locked), 0);
    chk("mid_rst_pos", int'(bus.pos), 0);

    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
